// File: rtl/adder_arbiter.sv
// Two-requester front end for a shared pipelined 32-bit adder: round-robin issue,
// credit-based flow control and one in-order response FIFO per requester.
module adder_arbiter #(
   parameter int LAT   = 2,
   parameter int DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req0_cin,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic        req1_cin,

   output logic        add_valid,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   output logic        add_cin,
   input  logic [31:0] add_sum,
   input  logic        add_cout,

   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_sum,
   output logic        rsp0_cout,

   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_sum,
   output logic        rsp1_cout,

   output logic        busy
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_IDX   = PW'(DEPTH - 1);

   logic [1:0]    req_valid;
   logic [1:0]    rsp_ready;
   logic [1:0]    eligible;
   logic [1:0]    grant;
   logic [1:0]    push;
   logic [1:0]    pop;
   logic [1:0]    rsp_valid;
   logic          last_grant;

   logic [CW-1:0] credit [2];
   logic [CW-1:0] count  [2];
   logic [PW-1:0] wr_ptr [2];
   logic [PW-1:0] rd_ptr [2];
   logic [32:0]   mem    [2][DEPTH];
   logic [32:0]   head   [2];

   logic [LAT:0]  tag_valid;
   logic [LAT:0]  tag_id;

   assign req_valid = {req1_valid, req0_valid};
   assign rsp_ready = {rsp1_ready, rsp0_ready};

   // last_grant holds the id granted most recently; reset value 1 favours requester 0.
   always_comb begin
      eligible = '0;
      grant    = '0;
      for (int unsigned r = 0; r < 2; r++) begin
         eligible[r] = req_valid[r] && (credit[r] != '0);
      end
      if (!reset) begin
         if (eligible == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
         end else begin
            grant = eligible;
         end
      end
   end

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         add_valid  <= 1'b0;
         add_a      <= '0;
         add_b      <= '0;
         add_cin    <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         add_valid <= |grant;
         if (|grant) begin
            add_a      <= grant[1] ? req1_a   : req0_a;
            add_b      <= grant[1] ? req1_b   : req0_b;
            add_cin    <= grant[1] ? req1_cin : req0_cin;
            last_grant <= grant[1];
         end
      end
   end

   // Stage LAT lines up with the adder result of the operation issued LAT cycles earlier.
   always_ff @(posedge clock) begin
      if (reset) begin
         tag_valid <= '0;
         tag_id    <= '0;
      end else begin
         tag_valid[0] <= |grant;
         tag_id[0]    <= grant[1];
         for (int unsigned i = 1; i <= LAT; i++) begin
            tag_valid[i] <= tag_valid[i-1];
            tag_id[i]    <= tag_id[i-1];
         end
      end
   end

   assign push = {tag_valid[LAT] & tag_id[LAT], tag_valid[LAT] & ~tag_id[LAT]};

   always_comb begin
      rsp_valid = '0;
      for (int unsigned r = 0; r < 2; r++) begin
         rsp_valid[r] = (count[r] != '0);
         head[r]      = rsp_valid[r] ? mem[r][rd_ptr[r]] : '0;
      end
   end

   assign pop = rsp_valid & rsp_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned r = 0; r < 2; r++) begin
            credit[r] <= CREDIT_MAX;
            count[r]  <= '0;
            wr_ptr[r] <= '0;
            rd_ptr[r] <= '0;
         end
      end else begin
         for (int unsigned r = 0; r < 2; r++) begin
            case ({grant[r], pop[r]})
               2'b10:   credit[r] <= credit[r] - CW'(1);
               2'b01:   credit[r] <= credit[r] + CW'(1);
               default: credit[r] <= credit[r];
            endcase
            case ({push[r], pop[r]})
               2'b10:   count[r] <= count[r] + CW'(1);
               2'b01:   count[r] <= count[r] - CW'(1);
               default: count[r] <= count[r];
            endcase
            if (push[r]) begin
               wr_ptr[r] <= (wr_ptr[r] == LAST_IDX) ? '0 : wr_ptr[r] + PW'(1);
            end
            if (pop[r]) begin
               rd_ptr[r] <= (rd_ptr[r] == LAST_IDX) ? '0 : rd_ptr[r] + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int unsigned r = 0; r < 2; r++) begin
         if (push[r]) begin
            mem[r][wr_ptr[r]] <= {add_cout, add_sum};
         end
      end
   end

   assign rsp0_valid = rsp_valid[0];
   assign rsp0_sum   = head[0][31:0];
   assign rsp0_cout  = head[0][32];
   assign rsp1_valid = rsp_valid[1];
   assign rsp1_sum   = head[1][31:0];
   assign rsp1_cout  = head[1][32];

   assign busy = add_valid | (|tag_valid) | (|rsp_valid);

   a_one_grant:  assert property (@(posedge clock) $onehot0(grant));
   a_no_ovf0:    assert property (@(posedge clock) disable iff (reset)
                                  !(push[0] && !pop[0] && count[0] == CREDIT_MAX));
   a_no_ovf1:    assert property (@(posedge clock) disable iff (reset)
                                  !(push[1] && !pop[1] && count[1] == CREDIT_MAX));

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: vector table for single operations plus
// hand-written sequences for arbitration, credit stall, FIFO and reset corners.
module tb_adder_arbiter;

   localparam int LAT   = 2;
   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        req0_valid, req0_ready, req0_cin;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready, req1_cin;
   logic [31:0] req1_a, req1_b;
   logic        add_valid, add_cin, add_cout;
   logic [31:0] add_a, add_b, add_sum;
   logic        rsp0_valid, rsp0_ready, rsp0_cout;
   logic [31:0] rsp0_sum;
   logic        rsp1_valid, rsp1_ready, rsp1_cout;
   logic [31:0] rsp1_sum;
   logic        busy;

   adder_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
      .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout),
      .busy(busy)
   );

   always #5 clock = ~clock;

   function automatic logic [32:0] add_ref(input logic [31:0] a, input logic [31:0] b, input logic cin);
      return {1'b0, a} + {1'b0, b} + {32'd0, cin};
   endfunction

   // Adder model: result of the operands presented with add_valid appears LAT cycles later.
   logic [32:0] pipe [LAT];
   always @(posedge clock) begin
      pipe[0] <= add_ref(add_a, add_b, add_cin);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign add_sum  = pipe[LAT-1][31:0];
   assign add_cout = pipe[LAT-1][32];

   int n_vec = 0;
   int n_err = 0;
   logic [32:0] q0 [$];
   logic [32:0] q1 [$];
   int got0, got1, acc, n0, n1;
   logic [32:0] e0, e1, held;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      q0.delete();
      q1.delete();
   endtask

   task automatic drive_op(input int r, input int n, output logic [32:0] e);
      logic [31:0] a, b;
      logic        c;
      a = 32'h1000_0000 * (r + 1) + n;
      b = 32'hFFFF_FFF0 + n * 7;
      c = n[0];
      if (r == 0) begin req0_a = a; req0_b = b; req0_cin = c; end
      else        begin req1_a = a; req1_b = b; req1_cin = c; end
      e = add_ref(a, b, c);
   endtask

   task automatic rsp_check(input string name);
      if (rsp0_valid && rsp0_ready) begin
         if (q0.size() == 0) check({name, "_rsp0_extra"}, rsp0_valid, 0);
         else check({name, "_rsp0"}, {rsp0_cout, rsp0_sum}, q0.pop_front());
         got0++;
      end
      if (rsp1_valid && rsp1_ready) begin
         if (q1.size() == 0) check({name, "_rsp1_extra"}, rsp1_valid, 0);
         else check({name, "_rsp1"}, {rsp1_cout, rsp1_sum}, q1.pop_front());
         got1++;
      end
   endtask

   typedef struct {
      logic        req;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] sum;
      logic        cout;
   } vec_t;

   vec_t vecs [6];
   vec_t v;

   initial begin
      vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
      vecs[1] = '{1'b1, 32'h1234_5678, 32'h0FED_CBA8, 1'b1, 32'h2222_2221, 1'b0};
      vecs[2] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0};
      vecs[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
      vecs[4] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0};
      vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};

      req0_a = '0; req0_b = '0; req0_cin = 1'b0;
      req1_a = '0; req1_b = '0; req1_cin = 1'b0;
      idle();

      // Reset state, with requests offered during reset.
      reset = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      tick();
      tick();
      check("rst_req0_ready", req0_ready, 0);
      check("rst_req1_ready", req1_ready, 0);
      check("rst_add_valid", add_valid, 0);
      check("rst_add_ops", {add_cin, add_a, add_b}, 0);
      check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
      check("rst_rsp_data", {rsp0_cout, rsp0_sum, rsp1_cout, rsp1_sum}, 0);
      check("rst_busy", busy, 0);
      check("rst_credit0", dut.credit[0], DEPTH);
      check("rst_credit1", dut.credit[1], DEPTH);
      reset = 1'b0;
      #1;
      check("post_rst_ready0", req0_ready, 1);
      check("post_rst_ready1", req1_ready, 0);
      idle();
      tick();

      // Single operations: latency and arithmetic corners.
      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         if (!v.req) begin req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_cin = v.cin; end
         else        begin req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_cin = v.cin; end
         #1;
         check("vec_ready", v.req ? req1_ready : req0_ready, 1);
         tick();
         idle();
         #1;
         check("vec_add_valid", add_valid, 1);
         check("vec_add_ops", {add_cin, add_a, add_b}, {v.cin, v.a, v.b});
         tick();
         check("vec_rsp_t2", v.req ? rsp1_valid : rsp0_valid, 0);
         check("vec_add_idle", add_valid, 0);
         check("vec_add_hold", {add_cin, add_a, add_b}, {v.cin, v.a, v.b});
         tick();
         check("vec_rsp_t3", v.req ? rsp1_valid : rsp0_valid, 0);
         tick();
         check("vec_rsp_t4", v.req ? rsp1_valid : rsp0_valid, 1);
         check("vec_rsp_data", v.req ? {rsp1_cout, rsp1_sum} : {rsp0_cout, rsp0_sum}, {v.cout, v.sum});
         if (v.req) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
         tick();
         idle();
         #1;
         check("vec_rsp_popped", {rsp1_valid, rsp0_valid}, 0);
         check("vec_busy", busy, 0);
      end

      // Round robin with both requesters saturating.
      do_reset();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      n0 = 0; n1 = 0; got0 = 0; got1 = 0;
      for (int c = 0; c < 8; c++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         drive_op(0, n0, e0);
         drive_op(1, n1, e1);
         #1;
         check("rr_ready0", req0_ready, (c % 2 == 0));
         check("rr_ready1", req1_ready, (c % 2 == 1));
         if (c > 0) check("rr_add_valid", add_valid, 1);
         rsp_check("rr");
         if (req0_ready) begin q0.push_back(e0); n0++; end
         if (req1_ready) begin q1.push_back(e1); n1++; end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #1;
         rsp_check("rr");
         tick();
      end
      check("rr_got0", got0, 4);
      check("rr_got1", got1, 4);
      check("rr_busy_end", busy, 0);

      // Credit exhaustion with a stalled response port.
      do_reset();
      n0 = 0; acc = 0;
      for (int c = 0; c < 10; c++) begin
         req0_valid = 1'b1;
         drive_op(0, n0, e0);
         #1;
         if (req0_ready) begin q0.push_back(e0); n0++; acc++; end
         tick();
      end
      check("cr_accepts", acc, 4);
      check("cr_stalled", req0_ready, 0);
      held = {rsp0_cout, rsp0_sum};
      check("cr_head", held, q0[0]);
      tick();
      check("cr_head_stable", {rsp0_cout, rsp0_sum}, held);
      rsp0_ready = 1'b1;
      #1;
      check("cr_ready_at_pop", req0_ready, 0);
      tick();
      void'(q0.pop_front());
      rsp0_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 8; c++) begin
         drive_op(0, n0, e0);
         #1;
         if (req0_ready) begin q0.push_back(e0); n0++; acc++; end
         tick();
      end
      check("cr_one_more", acc, 1);
      check("cr_head2", {rsp0_cout, rsp0_sum}, q0[0]);
      idle();
      rsp0_ready = 1'b1;
      got0 = 0;
      for (int c = 0; c < 8; c++) begin
         #1;
         rsp_check("cr");
         tick();
      end
      check("cr_drained", got0, 4);

      // Push and pop in the same cycle at occupancy 1, plus an accept (credit flat).
      do_reset();
      req0_valid = 1'b1; drive_op(0, 20, e0); q0.push_back(e0);
      tick();
      drive_op(0, 21, e0); q0.push_back(e0);
      tick();
      req0_valid = 1'b0;
      tick();
      tick();
      check("pp_occ_before", dut.count[0], 1);
      check("pp_head_a", {rsp0_cout, rsp0_sum}, q0[0]);
      rsp0_ready = 1'b1;
      req0_valid = 1'b1; drive_op(0, 22, e1);
      #1;
      check("pp_accept", req0_ready, 1);
      check("pp_credit_before", dut.credit[0], DEPTH - 2);
      tick();
      void'(q0.pop_front());
      q0.push_back(e1);
      idle();
      #1;
      check("pp_occ_after", dut.count[0], 1);
      check("pp_head_b", {rsp0_cout, rsp0_sum}, q0[0]);
      check("pp_credit_after", dut.credit[0], DEPTH - 2);
      rsp0_ready = 1'b1;
      got0 = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         rsp_check("pp");
         tick();
      end
      check("pp_drained", got0, 2);

      // Reset mid-flight discards everything.
      do_reset();
      req0_valid = 1'b1; drive_op(0, 30, e0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; drive_op(1, 31, e1);
      tick();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("mr_busy", busy, 0);
      check("mr_credit0", dut.credit[0], DEPTH);
      check("mr_credit1", dut.credit[1], DEPTH);
      for (int c = 0; c < 6; c++) begin
         check("mr_no_rsp", {rsp1_valid, rsp0_valid, busy}, 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameter LAT, default 2, meaning the fixed number of cycles from add_valid high to add_sum/add_cout valid on the shared pipelined 32-bit adder.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of result entries per requester response FIFO, which is also the per-requester credit limit.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: the reset, synchronous and active-high.
REQ-005 The block SHALL have ports req0_valid/req1_valid, input, 1 bit each: requester i offers an operation.
REQ-006 The block SHALL have ports req0_ready/req1_ready, output, 1 bit each: the operation from requester i is accepted this cycle.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 32 bits each: the operands.
REQ-008 The block SHALL have ports req0_cin/req1_cin, input, 1 bit each: the carry-in.
REQ-009 The block SHALL have port add_valid, output, 1 bit, registered: an operation is issued to the adder.
REQ-010 The block SHALL have ports add_a and add_b, output, 32 bits each, registered: the issued operands.
REQ-011 The block SHALL have port add_cin, output, 1 bit, registered: the issued carry-in.
REQ-012 The block SHALL have port add_sum, input, 32 bits: the adder result.
REQ-013 The block SHALL have port add_cout, input, 1 bit: the adder carry-out.
REQ-014 The block SHALL have ports rsp0_valid/rsp1_valid, output, 1 bit each: FIFO i is non-empty.
REQ-015 The block SHALL have ports rsp0_ready/rsp1_ready, input, 1 bit each: requester i consumes the FIFO head.
REQ-016 The block SHALL have ports rsp0_sum/rsp1_sum, output, 32 bits each, and rsp0_cout/rsp1_cout, output, 1 bit each: the FIFO i head entry.
REQ-017 The block SHALL have port busy, output, 1 bit: work is in flight or buffered.

Function
REQ-018 The block SHALL keep a credit counter per requester, 0..DEPTH, reset to DEPTH: -1 on accept, +1 on response pop, unchanged when both occur in the same cycle.
REQ-019 Requester i SHALL be eligible when reqi_valid=1 and credit_i is not 0.
REQ-020 When one requester is eligible it SHALL be granted; when both are eligible, the one not granted last SHALL be granted (round-robin).
REQ-021 The round-robin pointer SHALL update only on a grant, and after reset it SHALL favour requester 0.
REQ-022 reqi_ready SHALL equal grant_i, computed combinationally, with at most one grant per cycle; a handshake is reqi_valid and reqi_ready both high.
REQ-023 On a handshake in cycle t, add_valid/add_a/add_b/add_cin SHALL present the accepted operation in cycle t+1.
REQ-024 With no handshake, add_valid SHALL be 0 in the next cycle and add_a/add_b/add_cin SHALL hold their values.
REQ-025 A tag shift register of LAT+1 stages (valid bit plus requester id) SHALL track each issue so that, in cycle t+1+LAT, add_sum/add_cout are written to the FIFO of the issuing requester.
REQ-026 The result SHALL appear as rspi_valid=1 in cycle t+2+LAT (t+4 for LAT=2).
REQ-027 add_sum/add_cout SHALL be ignored in any cycle where the tag output stage is invalid.
REQ-028 Responses SHALL be delivered in acceptance order per requester; no ordering SHALL hold between requesters.
REQ-029 A FIFO push and pop in the same cycle SHALL both take effect, with occupancy unchanged; with a single entry, the new entry becomes the head in the next cycle.
REQ-030 The credit scheme SHALL guarantee that a FIFO never overflows; a push to a full FIFO is a design error and SHALL be flagged by an assertion.
REQ-031 rspi_sum/rspi_cout SHALL be stable while rspi_valid=1 and rspi_ready=0.
REQ-032 busy SHALL equal add_valid OR any tag stage valid OR any FIFO non-empty.
REQ-033 Full sustained throughput SHALL be one issue per cycle across both requesters.

Reset
REQ-034 While reset=1 at a rising edge: req*_ready=0, add_valid=0, add_a=0, add_b=0, add_cin=0, rsp*_valid=0, rsp*_sum=0, rsp*_cout=0, busy=0.
REQ-035 While reset=1 at a rising edge: credits=DEPTH, tag pipe cleared, FIFOs emptied, round-robin pointer set to favour requester 0.
REQ-036 A reset asserted mid-operation SHALL discard all in-flight and buffered results; adder outputs arriving afterwards SHALL be ignored.
REQ-037 Requests SHALL be accepted from the first cycle after reset deasserts.

Verification
REQ-038 Scenario: req0 only, a=0xFFFFFFFF, b=0x00000001, cin=0, accepted at t -> add_valid at t+1; rsp0_valid at t+4 with sum=0x00000000, cout=1.
REQ-039 Scenario: both requesters valid every cycle, responses always ready -> grants alternate 0,1,0,1 starting with 0; one add_valid per cycle; each requester's results in order.
REQ-040 Scenario: req0 valid continuously with rsp0_ready=0 -> exactly 4 accepts, then req0_ready=0; after one pop, exactly one further accept.
REQ-041 Scenario: push and pop on the same cycle with FIFO occupancy 1 -> occupancy remains 1, head advances, credit unchanged.
REQ-042 Scenario: reset pulsed one cycle after two accepts -> no rsp*_valid afterwards, credits=4, busy=0 in the cycle after reset.
REQ-043 Scenario: a=0x12345678, b=0x0FEDCBA8, cin=1 on req1 -> rsp1_sum=0x22222221, cout=0.
